// File: rtl/dac_frame_serializer.sv
// rtl/dac_frame_serializer.sv - latest-value-per-channel store feeding a round-robin 24-bit SPI DAC framer
module dac_frame_serializer #(
   parameter int         W_CHAN  = 5,
   parameter int         N_CHAN  = 8,
   parameter int         W_DIN   = 64,
   parameter int         CLK_DIV = 2,
   parameter logic [3:0] DAC_CMD = 4'b0011
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              dv_in,
   input  logic [W_CHAN-1:0] chan_in,
   input  logic [W_DIN-1:0]  data_in,
   output logic              dac_cs_n_out,
   output logic              dac_sclk_out,
   output logic              dac_din_out,
   output logic              busy_out,
   output logic              sent_out,
   output logic [W_CHAN-1:0] sent_chan_out,
   output logic              drop_out
);
   localparam int IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
   localparam int PER   = 2 * CLK_DIV;
   localparam int PH_W  = $clog2(PER + 1);
   localparam logic signed [W_DIN-1:0] MAX_V = W_DIN'(32767);
   localparam logic signed [W_DIN-1:0] MIN_V = W_DIN'(-32768);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_CS_HI} state_t;

   state_t              state_q, state_d;
   logic [N_CHAN-1:0]   pend_q, pend_d;
   logic [15:0]         code_q [N_CHAN];
   logic [15:0]         code_d [N_CHAN];
   logic [IDX_W-1:0]    rr_q, rr_d, cur_q, cur_d;
   logic [23:0]         shreg_q, shreg_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [4:0]          bit_q, bit_d;
   logic                cs_n_q, cs_n_d, sclk_q, sclk_d, din_q, din_d;
   logic                sent_q, sent_d, drop_q, drop_d;
   logic [W_CHAN-1:0]   sent_chan_q, sent_chan_d;

   logic signed [W_DIN-1:0] data_s;
   logic [15:0]         sat, conv;
   logic                accept;
   logic [IDX_W-1:0]    in_idx;
   logic                pick_ok;
   logic [IDX_W-1:0]    pick_idx;
   int                  pick_j;

   assign data_s = data_in;
   assign accept = dv_in && (32'(chan_in) < N_CHAN);
   assign in_idx = chan_in[IDX_W-1:0];

   // Saturate to int16, then flip the sign bit for the DAC's offset-binary coding
   always_comb begin
      sat = data_s[15:0];
      if (data_s > MAX_V)
         sat = 16'h7fff;
      else if (data_s < MIN_V)
         sat = 16'h8000;
      conv = {~sat[15], sat[14:0]};
   end

   // Descending scan so the lowest offset from rr_q is the one that sticks
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      pick_j   = 0;
      for (int i = N_CHAN - 1; i >= 0; i--) begin
         pick_j = 32'(rr_q) + i;
         if (pick_j >= N_CHAN)
            pick_j = pick_j - N_CHAN;
         if (pend_q[IDX_W'(pick_j)]) begin
            pick_ok  = 1'b1;
            pick_idx = IDX_W'(pick_j);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      code_d      = code_q;
      rr_d        = rr_q;
      cur_d       = cur_q;
      shreg_d     = shreg_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      din_d       = din_q;
      sent_d      = 1'b0;
      sent_chan_d = sent_chan_q;
      drop_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_ok) begin
               cur_d   = pick_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            shreg_d      = {DAC_CMD, 4'(cur_q), code_q[cur_q]};
            din_d        = DAC_CMD[3];
            cs_n_d       = 1'b0;
            sclk_d       = 1'b1;
            phase_d      = '0;
            bit_d        = '0;
            pend_d[cur_q] = 1'b0;
            rr_d         = (32'(cur_q) == N_CHAN - 1) ? '0 : cur_q + 1'b1;
            state_d      = S_SHIFT;
         end
         S_SHIFT: begin
            if (32'(phase_q) == PER - 1) begin
               phase_d = '0;
               if (bit_q == 5'd23) begin
                  cs_n_d      = 1'b1;
                  sclk_d      = 1'b0;
                  din_d       = 1'b0;
                  sent_d      = 1'b1;
                  sent_chan_d = W_CHAN'(cur_q);
                  state_d     = S_CS_HI;
               end else begin
                  bit_d   = bit_q + 5'd1;
                  shreg_d = {shreg_q[22:0], 1'b0};
                  din_d   = shreg_q[22];
                  sclk_d  = 1'b1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
               sclk_d  = (32'(phase_q) + 1 < CLK_DIV);
            end
         end
         S_CS_HI: begin
            if (32'(phase_q) == PER - 1) begin
               phase_d = '0;
               state_d = S_IDLE;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A write landing on the channel being loaded re-arms it rather than counting as a drop
      if (accept) begin
         drop_d         = pend_q[in_idx] && !(state_q == S_LOAD && cur_q == in_idx);
         code_d[in_idx] = conv;
         pend_d[in_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         for (int i = 0; i < N_CHAN; i++)
            code_q[i] <= '0;
         rr_q        <= '0;
         cur_q       <= '0;
         shreg_q     <= '0;
         phase_q     <= '0;
         bit_q       <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         din_q       <= 1'b0;
         sent_q      <= 1'b0;
         sent_chan_q <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         code_q      <= code_d;
         rr_q        <= rr_d;
         cur_q       <= cur_d;
         shreg_q     <= shreg_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         din_q       <= din_d;
         sent_q      <= sent_d;
         sent_chan_q <= sent_chan_d;
         drop_q      <= drop_d;
      end
   end

   assign dac_cs_n_out  = cs_n_q;
   assign dac_sclk_out  = sclk_q;
   assign dac_din_out   = din_q;
   assign busy_out      = (state_q != S_IDLE);
   assign sent_out      = sent_q;
   assign sent_chan_out = sent_chan_q;
   assign drop_out      = drop_q;
endmodule

// File: tb/tb_dac_frame_serializer.sv
// tb/tb_dac_frame_serializer.sv - scoreboard bench for dac_frame_serializer
module tb_dac_frame_serializer;
   logic        clk_in   = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        dv_in    = 1'b0;
   logic [4:0]  chan_in  = '0;
   logic [63:0] data_in  = '0;
   logic        dac_cs_n_out, dac_sclk_out, dac_din_out, busy_out, sent_out, drop_out;
   logic [4:0]  sent_chan_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_sent   = 0;
   int n_drop   = 0;
   logic [28:0] exp_q [$];

   logic [23:0] acc = '0;
   int          nbits = 0;
   logic        prev_sclk = 1'b0;

   dac_frame_serializer dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .dv_in         (dv_in),
      .chan_in       (chan_in),
      .data_in       (data_in),
      .dac_cs_n_out  (dac_cs_n_out),
      .dac_sclk_out  (dac_sclk_out),
      .dac_din_out   (dac_din_out),
      .busy_out      (busy_out),
      .sent_out      (sent_out),
      .sent_chan_out (sent_chan_out),
      .drop_out      (drop_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic write(input logic [4:0] ch, input logic [63:0] d);
      dv_in   = 1'b1;
      chan_in = ch;
      data_in = d;
      step();
      dv_in   = 1'b0;
   endtask

   task automatic expect_frame(input logic [4:0] ch, input logic [23:0] frame);
      exp_q.push_back({ch, frame});
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 1000) begin
         step();
         n++;
         if (busy_out) quiet = 0;
         else quiet++;
      end
      if (quiet < 4) fail_now({name, "_timeout"});
   endtask

   // Monitor: captures din on every sclk falling edge under cs_n, compares on sent_out
   always @(negedge clk_in) begin
      logic [28:0] e;
      if (!rst_n_in) begin
         acc = '0;
         nbits = 0;
         prev_sclk = 1'b0;
      end else begin
         if (!dac_cs_n_out && prev_sclk && !dac_sclk_out) begin
            acc = {acc[22:0], dac_din_out};
            nbits++;
         end
         if (drop_out) n_drop++;
         if (sent_out) begin
            n_sent++;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_frame");
            end else begin
               e = exp_q.pop_front();
               check("frame_bits", acc, e[23:0]);
               check("frame_nbits", nbits, 24);
               check("sent_chan", sent_chan_out, e[28:24]);
            end
         end
         if (dac_cs_n_out) begin
            acc = '0;
            nbits = 0;
         end
         prev_sclk = dac_sclk_out;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int len, cslow, s0, d0, seen;
      step();
      step();
      check("rst_cs_n", dac_cs_n_out, 1);
      check("rst_sclk", dac_sclk_out, 0);
      check("rst_din", dac_din_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_sent", sent_out, 0);
      check("rst_sent_chan", sent_chan_out, 0);
      check("rst_drop", drop_out, 0);
      rst_n_in = 1'b1;
      step();

      // 1: chan 2, data 0 -> 0x328000, LOAD two cycles after dv, 101-cycle frame
      expect_frame(5'd2, 24'h328000);
      write(5'd2, 64'd0);
      check("t1_busy_t1", busy_out, 0);
      step();
      check("t1_busy_t2", busy_out, 1);
      len = 0;
      cslow = 0;
      while (busy_out && len < 300) begin
         len++;
         if (!dac_cs_n_out) cslow++;
         step();
      end
      check("t1_frame_len", len, 101);
      check("t1_cs_low_len", cslow, 96);
      wait_idle("t1");

      // 2: clamp and offset-binary boundaries
      expect_frame(5'd0, 24'h30FFFF); write(5'd0, 64'd100000);            wait_idle("t2a");
      expect_frame(5'd1, 24'h317FFF); write(5'd1, 64'hFFFF_FFFF_FFFF_FFFF); wait_idle("t2b");
      expect_frame(5'd7, 24'h370000); write(5'd7, 64'hFFFF_FF00_0000_0000); wait_idle("t2c");
      expect_frame(5'd2, 24'h32FFFF); write(5'd2, 64'd32767);             wait_idle("t2d");
      expect_frame(5'd3, 24'h330000); write(5'd3, 64'hFFFF_FFFF_FFFF_8000); wait_idle("t2e");

      // 3: writes to 5,1,6 while busy on 0 -> served 1,5,6
      s0 = n_sent; d0 = n_drop;
      expect_frame(5'd0, 24'h309234);
      expect_frame(5'd1, 24'h317ED4);
      expect_frame(5'd5, 24'h358005);
      expect_frame(5'd6, 24'h36F000);
      write(5'd0, 64'h1234);
      step();
      check("t3_busy_load", busy_out, 1);
      write(5'd5, 64'd5);
      write(5'd1, 64'hFFFF_FFFF_FFFF_FED4);
      write(5'd6, 64'h7000);
      wait_idle("t3");
      check("t3_frames", n_sent - s0, 4);
      check("t3_drops", n_drop - d0, 0);

      // 4: two writes to chan 3 before service -> one drop, one frame with newest code
      s0 = n_sent; d0 = n_drop;
      expect_frame(5'd3, 24'h338020);
      write(5'd3, 64'h10);
      write(5'd3, 64'h20);
      wait_idle("t4");
      check("t4_frames", n_sent - s0, 1);
      check("t4_drops", n_drop - d0, 1);

      // 5: write chan 4 during its own LOAD -> old code now, new code in a follow-up frame
      s0 = n_sent; d0 = n_drop;
      expect_frame(5'd4, 24'h348100);
      expect_frame(5'd4, 24'h348200);
      write(5'd4, 64'h100);
      step();
      check("t5_busy_load", busy_out, 1);
      write(5'd4, 64'h200);
      wait_idle("t5");
      check("t5_frames", n_sent - s0, 2);
      check("t5_drops", n_drop - d0, 0);

      // 6: reset in bit 10 aborts at once and clears pending channels
      s0 = n_sent;
      write(5'd2, 64'h55);
      step();
      write(5'd5, 64'h66);
      repeat (41) step();
      check("t6_in_frame", dac_cs_n_out, 0);
      rst_n_in = 1'b0;
      #1;
      check("t6_rst_cs_n", dac_cs_n_out, 1);
      check("t6_rst_sclk", dac_sclk_out, 0);
      check("t6_rst_busy", busy_out, 0);
      step();
      step();
      rst_n_in = 1'b1;
      seen = 0;
      repeat (30) begin
         step();
         if (busy_out) seen++;
      end
      check("t6_no_frame_after", seen, 0);
      check("t6_no_sent", n_sent - s0, 0);

      // 7: out-of-range channel is ignored
      s0 = n_sent; d0 = n_drop;
      write(5'd8, 64'h1234);
      write(5'd8, 64'h4321);
      seen = 0;
      repeat (30) begin
         step();
         if (busy_out) seen++;
      end
      check("t7_no_busy", seen, 0);
      check("t7_no_sent", n_sent - s0, 0);
      check("t7_no_drop", n_drop - d0, 0);

      check("sb_empty", exp_q.size(), 0);
      check("total_frames", n_sent, 13);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
